// File: rtl/acia_pkg.sv
// Shared encodings and divider helpers for the buffered ACIA transmitter.
// Build option ACIA_TX_PARITY_EN adds an even-parity bit and the PARITY state.
package acia_pkg;

`ifdef ACIA_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;
    localparam int FRAME_BITS = 11;
`else
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd4
    } tx_state_t;
    localparam int FRAME_BITS = 10;
`endif

    localparam int CLK_FREQ_DEF = 4000000;
    localparam int SYM_RATE_DEF = 9600;

    // Truncating divide: the receiver side uses the same rounding.
    function automatic int baud_div(input int freq, input int rate);
        return freq / rate;
    endfunction

    function automatic int div_width(input int div);
        return (div < 2) ? 1 : $clog2(div);
    endfunction

    localparam int DIV_DEF   = baud_div(CLK_FREQ_DEF, SYM_RATE_DEF);
    localparam int DIV_W_DEF = div_width(DIV_DEF);

endpackage

// File: rtl/acia_tx_buf_if.sv
// Byte-sink bus between a producer and acia_tx_buf: write strobe, status and the serial line.
interface acia_tx_buf_if #(
    parameter int FIFO_DEPTH = 16
) ();
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]       tx_dat;
    logic             tx_stb;
    logic             tx_ovf_clr;
    logic             tx_serial;
    logic             tx_full;
    logic             tx_empty;
    logic             tx_busy;
    logic             tx_ovf;
    logic [CNT_W-1:0] tx_count;

    modport master (
        output tx_dat, tx_stb, tx_ovf_clr,
        input  tx_serial, tx_full, tx_empty, tx_busy, tx_ovf, tx_count
    );

    modport slave (
        input  tx_dat, tx_stb, tx_ovf_clr,
        output tx_serial, tx_full, tx_empty, tx_busy, tx_ovf, tx_count
    );
endinterface

// File: rtl/acia_tx_fifo.sv
// Synchronous FIFO with registered full/empty/count; full and empty reflect the post-update count.
module acia_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_nxt;
    logic             push_ok;
    logic             pop_ok;

    // Full is the registered state, so a strobe while full is refused even if a pop happens.
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        if (push_ok && !pop_ok)
            count_nxt = count + CW'(1);
        else if (pop_ok && !push_ok)
            count_nxt = count - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end
endmodule

// File: rtl/acia_tx_buf.sv
// Buffered 8N1 serial transmitter, LSB first, timed by the pclk enable.
// Define ACIA_TX_PARITY_EN for 8E1 frames (even parity between data and stop).
//
// state     | meaning
// ST_IDLE   | line high, waiting for a queued byte at a pclk tick
// ST_START  | start bit (0) for DIV ticks
// ST_DATA   | 8 data bits, LSB first, bit_idx 0..7
// ST_PARITY | even parity of the data byte (parity build only)
// ST_STOP   | stop bit (1); reloads straight into START when more bytes wait
module acia_tx_buf
    import acia_pkg::*;
#(
    parameter int clk_freq   = CLK_FREQ_DEF,
    parameter int sym_rate   = SYM_RATE_DEF,
    parameter int FIFO_DEPTH = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         pclk,
    acia_tx_buf_if.slave bus
);
    localparam int DIV   = baud_div(clk_freq, sym_rate);
    localparam int DIV_W = div_width(DIV);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    tx_state_t        state, state_nxt;
    logic [DIV_W-1:0] baud_cnt, baud_cnt_nxt;
    logic [2:0]       bit_idx, bit_idx_nxt;
    logic [7:0]       shreg, shreg_nxt;
    logic             line, line_nxt;
    logic             bit_end;
    logic             load;
    logic             tx_ovf_q;
    logic             fifo_full;
    logic             fifo_empty;
    logic [7:0]       fifo_head;
    logic [CNT_W-1:0] fifo_count;
`ifdef ACIA_TX_PARITY_EN
    logic             par, par_nxt;
`endif

    acia_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (bus.tx_stb),
        .pop   (load),
        .din   (bus.tx_dat),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_nxt    = state;
        baud_cnt_nxt = baud_cnt;
        bit_idx_nxt  = bit_idx;
        shreg_nxt    = shreg;
        line_nxt     = line;
        load         = 1'b0;
        bit_end      = (baud_cnt == DIV_W'(DIV - 1));
`ifdef ACIA_TX_PARITY_EN
        par_nxt      = par;
`endif
        if (pclk) begin
            baud_cnt_nxt = bit_end ? '0 : baud_cnt + DIV_W'(1);
            unique case (state)
                ST_IDLE: begin
                    baud_cnt_nxt = '0;
                    load         = ~fifo_empty;
                end
                ST_START: begin
                    if (bit_end) begin
                        state_nxt   = ST_DATA;
                        bit_idx_nxt = 3'd0;
                        line_nxt    = shreg[0];
                        shreg_nxt   = {1'b0, shreg[7:1]};
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        if (bit_idx == 3'd7) begin
`ifdef ACIA_TX_PARITY_EN
                            state_nxt = ST_PARITY;
                            line_nxt  = par;
`else
                            state_nxt = ST_STOP;
                            line_nxt  = 1'b1;
`endif
                        end else begin
                            bit_idx_nxt = bit_idx + 3'd1;
                            line_nxt    = shreg[0];
                            shreg_nxt   = {1'b0, shreg[7:1]};
                        end
                    end
                end
`ifdef ACIA_TX_PARITY_EN
                ST_PARITY: begin
                    if (bit_end) begin
                        state_nxt = ST_STOP;
                        line_nxt  = 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (bit_end) begin
                        state_nxt = ST_IDLE;
                        line_nxt  = 1'b1;
                        load      = ~fifo_empty;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    line_nxt  = 1'b1;
                end
            endcase

            // Back-to-back frames reload here so no idle tick appears between them.
            if (load) begin
                state_nxt    = ST_START;
                baud_cnt_nxt = '0;
                shreg_nxt    = fifo_head;
                line_nxt     = 1'b0;
`ifdef ACIA_TX_PARITY_EN
                par_nxt      = ^fifo_head;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_idx  <= 3'd0;
            shreg    <= 8'h00;
            line     <= 1'b1;
            tx_ovf_q <= 1'b0;
`ifdef ACIA_TX_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_cnt_nxt;
            bit_idx  <= bit_idx_nxt;
            shreg    <= shreg_nxt;
            line     <= line_nxt;
`ifdef ACIA_TX_PARITY_EN
            par      <= par_nxt;
`endif
            if (bus.tx_ovf_clr)
                tx_ovf_q <= 1'b0;
            else if (bus.tx_stb && fifo_full)
                tx_ovf_q <= 1'b1;
        end
    end

    assign bus.tx_serial = line;
    assign bus.tx_full   = fifo_full;
    assign bus.tx_empty  = fifo_empty;
    assign bus.tx_busy   = (state != ST_IDLE);
    assign bus.tx_ovf    = tx_ovf_q;
    assign bus.tx_count  = fifo_count;
endmodule

// File: tb/tb_acia_tx_buf.sv
// Directed bench for acia_tx_buf at clk_freq=16, sym_rate=4 (DIV=4), FIFO_DEPTH=4.
module tb_acia_tx_buf;
    import acia_pkg::*;

    localparam int DEPTH  = 4;
    localparam int NB     = FRAME_BITS;
    localparam int WAIT_T = 400;

    logic clk = 1'b0;
    logic reset;
    logic pclk = 1'b0;
    int   pclk_div = 1;
    int   pclk_ph = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    acia_tx_buf_if #(.FIFO_DEPTH(DEPTH)) bus ();

    acia_tx_buf #(
        .clk_freq   (16),
        .sym_rate   (4),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .pclk  (pclk),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (pclk_div == 0) begin
            pclk = 1'b0;
        end else begin
            pclk = (pclk_ph == 0);
            pclk_ph = (pclk_ph + 1) % pclk_div;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic write_byte(input logic [7:0] b);
        bus.tx_dat = b;
        bus.tx_stb = 1'b1;
        @(negedge clk);
        bus.tx_stb = 1'b0;
    endtask

    task automatic set_pclk(input int div);
        pclk_div = div;
        pclk_ph  = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_start(input string tag, output int gap);
        gap = 0;
        while (bus.tx_serial !== 1'b0 && gap < WAIT_T) begin
            @(negedge clk);
            gap++;
        end
        check({tag, "_start_seen"}, 64'(gap < WAIT_T), 64'd1);
    endtask

    // Follows one frame sample by sample; returns on the last sample of the stop bit.
    task automatic watch_frame(input string tag, input logic [7:0] b, input int per_bit,
                               input bit want_gap0, input int exp_cnt);
        logic [15:0] exp_f;
        logic [15:0] obs;
        int gap, glitch, busy_n, cnt0;
        exp_f = '0;
        obs   = '0;
        glitch = 0;
        busy_n = 0;
        for (int i = 0; i < 8; i++) exp_f[1+i] = b[i];
`ifdef ACIA_TX_PARITY_EN
        exp_f[9] = ^b;
`endif
        exp_f[NB-1] = 1'b1;
        @(negedge clk);
        wait_start(tag, gap);
        if (gap >= WAIT_T) return;
        cnt0 = int'(bus.tx_count);
        for (int bi = 0; bi < NB; bi++) begin
            for (int s = 0; s < per_bit; s++) begin
                if (s == per_bit / 2) obs[bi] = bus.tx_serial;
                if (bus.tx_serial !== exp_f[bi]) glitch++;
                if (bus.tx_busy === 1'b1) busy_n++;
                if (!(bi == NB - 1 && s == per_bit - 1)) @(negedge clk);
            end
        end
        check({tag, "_bits"}, 64'(obs), 64'(exp_f));
        check({tag, "_timing"}, 64'(glitch), 64'd0);
        check({tag, "_busy_clks"}, 64'(busy_n), 64'(NB * per_bit));
        if (want_gap0) check({tag, "_gap"}, 64'(gap), 64'd0);
        if (exp_cnt >= 0) check({tag, "_count"}, 64'(cnt0), 64'(exp_cnt));
    endtask

    int gap5, low_n, busy5;
    int rx_got, rx_bad, rx_err, wr_tmo;

    initial begin
        reset = 1'b1;
        bus.tx_dat = 8'h00;
        bus.tx_stb = 1'b0;
        bus.tx_ovf_clr = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_serial", 64'(bus.tx_serial), 64'd1);
        check("rst_full",   64'(bus.tx_full),   64'd0);
        check("rst_empty",  64'(bus.tx_empty),  64'd1);
        check("rst_busy",   64'(bus.tx_busy),   64'd0);
        check("rst_ovf",    64'(bus.tx_ovf),    64'd0);
        check("rst_count",  64'(bus.tx_count),  64'd0);

        // 1: single frame A5
        write_byte(8'hA5);
        watch_frame("t1_a5", 8'hA5, 4, 1'b1, 0);
        @(negedge clk);
        check("t1_idle_busy", 64'(bus.tx_busy), 64'd0);
        check("t1_idle_line", 64'(bus.tx_serial), 64'd1);

        // 2: three queued bytes, contiguous frames
        set_pclk(0);
        write_byte(8'h00);
        write_byte(8'hFF);
        write_byte(8'h55);
        check("t2_count3", 64'(bus.tx_count), 64'd3);
        pclk_div = 1;
        pclk_ph = 0;
        watch_frame("t2_00", 8'h00, 4, 1'b0, 2);
        watch_frame("t2_ff", 8'hFF, 4, 1'b1, 1);
        watch_frame("t2_55", 8'h55, 4, 1'b1, 0);
        check("t2_empty", 64'(bus.tx_empty), 64'd1);

        // 3: overflow with a 4-deep FIFO
        set_pclk(0);
        write_byte(8'h11);
        write_byte(8'h22);
        write_byte(8'h33);
        write_byte(8'h44);
        check("t3_full",  64'(bus.tx_full), 64'd1);
        check("t3_count", 64'(bus.tx_count), 64'd4);
        check("t3_noovf", 64'(bus.tx_ovf), 64'd0);
        write_byte(8'h55);
        write_byte(8'h66);
        check("t3_ovf_set", 64'(bus.tx_ovf), 64'd1);
        check("t3_count_kept", 64'(bus.tx_count), 64'd4);
        bus.tx_ovf_clr = 1'b1;
        @(negedge clk);
        check("t3_ovf_clr", 64'(bus.tx_ovf), 64'd0);
        bus.tx_dat = 8'h77;
        bus.tx_stb = 1'b1;
        @(negedge clk);
        bus.tx_stb = 1'b0;
        bus.tx_ovf_clr = 1'b0;
        check("t3_clr_wins", 64'(bus.tx_ovf), 64'd0);
        write_byte(8'h88);
        check("t3_ovf_again", 64'(bus.tx_ovf), 64'd1);
        bus.tx_ovf_clr = 1'b1;
        @(negedge clk);
        bus.tx_ovf_clr = 1'b0;
        check("t3_ovf_clr2", 64'(bus.tx_ovf), 64'd0);
        pclk_div = 1;
        pclk_ph = 0;
        watch_frame("t3_11", 8'h11, 4, 1'b0, 3);
        watch_frame("t3_22", 8'h22, 4, 1'b1, 2);
        watch_frame("t3_33", 8'h33, 4, 1'b1, 1);
        watch_frame("t3_44", 8'h44, 4, 1'b1, 0);
        @(negedge clk);
        check("t3_dropped_line", 64'(bus.tx_serial), 64'd1);
        check("t3_dropped_busy", 64'(bus.tx_busy), 64'd0);

        // 4: pclk every 4th clk -> 16 clk per bit, frozen between ticks
        set_pclk(4);
        write_byte(8'h3C);
        watch_frame("t4_3c", 8'h3C, 16, 1'b0, 0);
        set_pclk(1);
        repeat (20) @(negedge clk);

        // 5: reset during data bit 3 of 0F with two bytes queued
        set_pclk(0);
        write_byte(8'h0F);
        write_byte(8'hA1);
        write_byte(8'hB2);
        pclk_div = 1;
        pclk_ph = 0;
        @(negedge clk);
        wait_start("t5", gap5);
        repeat (17) @(negedge clk);
        check("t5_bit3_line", 64'(bus.tx_serial), 64'd1);
        check("t5_pre_count", 64'(bus.tx_count), 64'd2);
        reset = 1'b1;
        @(negedge clk);
        check("t5_line_high", 64'(bus.tx_serial), 64'd1);
        check("t5_count0", 64'(bus.tx_count), 64'd0);
        check("t5_empty", 64'(bus.tx_empty), 64'd1);
        check("t5_busy0", 64'(bus.tx_busy), 64'd0);
        reset = 1'b0;
        low_n = 0;
        busy5 = 0;
        repeat (120) begin
            @(negedge clk);
            if (bus.tx_serial !== 1'b1) low_n++;
            if (bus.tx_busy !== 1'b0) busy5++;
        end
        check("t5_no_frames", 64'(low_n), 64'd0);
        check("t5_stay_idle", 64'(busy5), 64'd0);

        // 6: loopback of all 256 byte values through a bench-side receiver
        rx_got = 0;
        rx_bad = 0;
        rx_err = 0;
        wr_tmo = 0;
        fork
            begin
                for (int k = 0; k < 256; k++) begin
                    int n;
                    n = 0;
                    while (bus.tx_full === 1'b1 && n < WAIT_T) begin
                        @(negedge clk);
                        n++;
                    end
                    if (n >= WAIT_T) wr_tmo++;
                    write_byte(8'(k));
                end
            end
            begin
                for (int k = 0; k < 256; k++) begin
                    int n;
                    logic [7:0] d;
                    n = 0;
                    while (bus.tx_serial !== 1'b0 && n < WAIT_T) begin
                        @(negedge clk);
                        n++;
                    end
                    if (n >= WAIT_T) break;
                    @(negedge clk);
                    if (bus.tx_serial !== 1'b0) rx_err++;
                    for (int i = 0; i < 8; i++) begin
                        repeat (4) @(negedge clk);
                        d[i] = bus.tx_serial;
                    end
`ifdef ACIA_TX_PARITY_EN
                    repeat (4) @(negedge clk);
                    if (bus.tx_serial !== ^d) rx_err++;
`endif
                    repeat (4) @(negedge clk);
                    if (bus.tx_serial !== 1'b1) rx_err++;
                    if (d !== 8'(k)) rx_bad++;
                    rx_got++;
                end
            end
        join
        check("t6_rx_count", 64'(rx_got), 64'd256);
        check("t6_rx_data", 64'(rx_bad), 64'd0);
        check("t6_rx_err", 64'(rx_err), 64'd0);
        check("t6_wr_stall", 64'(wr_tmo), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
